// File: rtl/tree_pkg.sv
// Shared definitions for the multibit-tree updater: request op encodings,
// FSM states and the tag -> (group, leaf) index split.
package tree_pkg;

  localparam logic OP_INSERT = 1'b1;
  localparam logic OP_DELETE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UPDATE,
    ST_RESP
  } tree_state_t;

  // Upper lvl_bits of the tag select the group, lower lvl_bits the leaf bit.
  function automatic int unsigned tag_group(input int unsigned tag,
                                            input int unsigned lvl_bits);
    return tag >> lvl_bits;
  endfunction

  function automatic int unsigned tag_leaf(input int unsigned tag,
                                           input int unsigned lvl_bits);
    return tag & ((32'd1 << lvl_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/tree_leaf_update.sv
// Combinational next-leaf-word / next-count / error for one tree group.
// Counter ports exist only when TREE_DUP_COUNT_EN is defined.
module tree_leaf_update
  import tree_pkg::*;
#(
  parameter int unsigned LVL_BITS = 3
`ifdef TREE_DUP_COUNT_EN
  ,
  parameter int unsigned CNT_W = 4
`endif
) (
  input  logic [2**LVL_BITS-1:0] leaf_word,
  input  logic [LVL_BITS-1:0]    leaf_idx,
  input  logic                   op,
`ifdef TREE_DUP_COUNT_EN
  input  logic [CNT_W-1:0]       cnt,
  output logic [CNT_W-1:0]       next_cnt,
`endif
  output logic [2**LVL_BITS-1:0] next_word,
  output logic                   err
);

  always_comb begin
    next_word = leaf_word;
    err       = 1'b0;
`ifdef TREE_DUP_COUNT_EN
    next_cnt  = cnt;
    if (op == OP_INSERT) begin
      if (cnt == '1) begin
        err = 1'b1;
      end else begin
        next_cnt            = cnt + CNT_W'(1);
        next_word[leaf_idx] = 1'b1;
      end
    end else begin
      if (cnt == '0 || !leaf_word[leaf_idx]) begin
        err = 1'b1;
      end else begin
        next_cnt = cnt - CNT_W'(1);
        // Leaf bit tracks occupancy: it drops only with the last duplicate.
        if (cnt == CNT_W'(1)) next_word[leaf_idx] = 1'b0;
      end
    end
`else
    if (op == OP_INSERT) begin
      if (leaf_word[leaf_idx]) err = 1'b1;
      else                     next_word[leaf_idx] = 1'b1;
    end else begin
      if (!leaf_word[leaf_idx]) err = 1'b1;
      else                      next_word[leaf_idx] = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/multibit_tree_updater.sv
// Insert/delete read-modify-write engine for the two-level tag bitmap tree.
// Optional per-tag duplicate counters are enabled by TREE_DUP_COUNT_EN.
module multibit_tree_updater
  import tree_pkg::*;
#(
  parameter int unsigned LVL_BITS = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_op,
  input  logic [2*LVL_BITS-1:0]           req_tag,
  output logic                            done_valid,
  output logic                            done_err,
  output logic [2**LVL_BITS-1:0]          lvl0_map,
  output logic [2**(2*LVL_BITS)-1:0]      lvl1_map,
  output logic [2*LVL_BITS+CNT_W-1:0]     tag_count
);

  localparam int unsigned TAG_W  = 2 * LVL_BITS;
  localparam int unsigned FANOUT = 2 ** LVL_BITS;
  localparam int unsigned CW     = TAG_W + CNT_W;

  tree_state_t state, state_nxt;

  logic [TAG_W-1:0]    tag_q;
  logic                op_q;
  logic [FANOUT-1:0]   ld_word;
  logic [FANOUT-1:0]   nxt_word;
  logic                upd_err;
  logic [LVL_BITS-1:0] grp;
  logic [LVL_BITS-1:0] leaf;
  logic [TAG_W-1:0]    word_base;

  assign grp       = LVL_BITS'(tag_group(32'(tag_q), LVL_BITS));
  assign leaf      = LVL_BITS'(tag_leaf(32'(tag_q), LVL_BITS));
  assign word_base = {grp, {LVL_BITS{1'b0}}};

`ifdef TREE_DUP_COUNT_EN
  logic [CNT_W-1:0] cnt_mem [2**TAG_W];
  logic [CNT_W-1:0] ld_cnt;
  logic [CNT_W-1:0] nxt_cnt;
`endif

  tree_leaf_update #(
    .LVL_BITS (LVL_BITS)
`ifdef TREE_DUP_COUNT_EN
    ,
    .CNT_W    (CNT_W)
`endif
  ) u_leaf_update (
    .leaf_word (ld_word),
    .leaf_idx  (leaf),
    .op        (op_q),
`ifdef TREE_DUP_COUNT_EN
    .cnt       (ld_cnt),
    .next_cnt  (nxt_cnt),
`endif
    .next_word (nxt_word),
    .err       (upd_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only.
  assign req_ready  = (state == ST_IDLE);
  assign done_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= '0;
      op_q      <= OP_DELETE;
      ld_word   <= '0;
      done_err  <= 1'b0;
      lvl0_map  <= '0;
      lvl1_map  <= '0;
      tag_count <= '0;
`ifdef TREE_DUP_COUNT_EN
      ld_cnt    <= '0;
      for (int unsigned i = 0; i < 2**TAG_W; i++) cnt_mem[i] <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tag_q <= req_tag;
            op_q  <= req_op;
          end
        end
        ST_LOAD: begin
          ld_word <= lvl1_map[word_base +: FANOUT];
`ifdef TREE_DUP_COUNT_EN
          ld_cnt  <= cnt_mem[tag_q];
`endif
        end
        ST_UPDATE: begin
          done_err <= upd_err;
          if (!upd_err) begin
            // Leaf word and its summary bit move on the same edge.
            lvl1_map[word_base +: FANOUT] <= nxt_word;
            lvl0_map[grp]                 <= |nxt_word;
            if (op_q == OP_INSERT) tag_count <= tag_count + CW'(1);
            else                   tag_count <= tag_count - CW'(1);
`ifdef TREE_DUP_COUNT_EN
            cnt_mem[tag_q] <= nxt_cnt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multibit_tree_updater.sv
// Directed self-checking bench for multibit_tree_updater (LVL_BITS = 3).
// Duplicate-count expectations follow TREE_DUP_COUNT_EN when defined.
module tb_multibit_tree_updater;
  import tree_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [5:0]  req_tag;
  logic        done_valid;
  logic        done_err;
  logic [7:0]  lvl0_map;
  logic [63:0] lvl1_map;
  logic [9:0]  tag_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  multibit_tree_updater #(.LVL_BITS(3), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .done_valid (done_valid),
    .done_err   (done_err),
    .lvl0_map   (lvl0_map),
    .lvl1_map   (lvl1_map),
    .tag_count  (tag_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_tree(input string tag, input logic [63:0] e1, input logic [7:0] e0,
                            input logic [9:0] ecnt);
    check({tag, "/lvl1"}, lvl1_map, e1);
    check({tag, "/lvl0"}, 64'(lvl0_map), 64'(e0));
    check({tag, "/count"}, 64'(tag_count), 64'(ecnt));
  endtask

  // Issues one request and checks latency (done in cycle 3), error flag,
  // one-cycle done pulse and req_ready back in cycle 4.
  task automatic run_req(input string tag, input logic op, input logic [5:0] t,
                         input logic exp_err);
    int unsigned lat;
    lat = 0;
    @(negedge clk);
    check({tag, "/ready_pre"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      if (done_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "/latency"}, 64'(lat), 64'd3);
    check({tag, "/err"}, 64'(done_err), 64'(exp_err));
    check({tag, "/ready_in_done"}, 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 64'(done_valid), 64'd0);
    check({tag, "/ready_post"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_DELETE;
    req_tag   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/ready", 64'(req_ready), 64'd1);
    check("rst/done", 64'(done_valid), 64'd0);
    check("rst/err", 64'(done_err), 64'd0);
    check_tree("rst", 64'h0, 8'h00, 10'd0);
    @(negedge clk);
    rst = 1'b0;

    run_req("ins2d", OP_INSERT, 6'h2D, 1'b0);
    check_tree("ins2d", 64'h0000_2000_0000_0000, 8'h20, 10'd1);
    run_req("del2d", OP_DELETE, 6'h2D, 1'b0);
    check_tree("del2d", 64'h0, 8'h00, 10'd0);

    run_req("del07_empty", OP_DELETE, 6'h07, 1'b1);
    check_tree("del07_empty", 64'h0, 8'h00, 10'd0);

    run_req("dup1", OP_INSERT, 6'h2D, 1'b0);
`ifdef TREE_DUP_COUNT_EN
    run_req("dup2", OP_INSERT, 6'h2D, 1'b0);
    check_tree("dup2", 64'h0000_2000_0000_0000, 8'h20, 10'd2);
    run_req("dup_del1", OP_DELETE, 6'h2D, 1'b0);
    check_tree("dup_del1", 64'h0000_2000_0000_0000, 8'h20, 10'd1);
`else
    run_req("dup2", OP_INSERT, 6'h2D, 1'b1);
    check_tree("dup2", 64'h0000_2000_0000_0000, 8'h20, 10'd1);
`endif
    run_req("dup_clean", OP_DELETE, 6'h2D, 1'b0);
    check_tree("dup_clean", 64'h0, 8'h00, 10'd0);

    run_req("ins28", OP_INSERT, 6'h28, 1'b0);
    run_req("ins2f", OP_INSERT, 6'h2F, 1'b0);
    check_tree("ins28_2f", 64'h0000_8100_0000_0000, 8'h20, 10'd2);
    run_req("del28", OP_DELETE, 6'h28, 1'b0);
    check_tree("del28", 64'h0000_8000_0000_0000, 8'h20, 10'd1);
    run_req("del2f", OP_DELETE, 6'h2F, 1'b0);
    check_tree("del2f", 64'h0, 8'h00, 10'd0);

    run_req("ins07", OP_INSERT, 6'h07, 1'b0);
    run_req("ins3f", OP_INSERT, 6'h3F, 1'b0);
    check_tree("edges", 64'h8000_0000_0000_0080, 8'h81, 10'd2);

    // Reset while an insert sits in UPDATE: dropped, no done pulse.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_tag   = 6'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid/ready", 64'(req_ready), 64'd1);
    check("rst_mid/done", 64'(done_valid), 64'd0);
    check_tree("rst_mid", 64'h0, 8'h00, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_mid/no_done", 64'(done_valid), 64'd0);
    end

    run_req("post_rst", OP_INSERT, 6'h00, 1'b0);
    check_tree("post_rst", 64'h1, 8'h01, 10'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
